// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin arbiter sharing one fp32 multiplier between
// NUM_REQ requesters. A tag FIFO records the requester index of each issued
// op so that in-order results can be routed back to their owners.
// Optional build macro: FP_MUL_ARB_STATS_EN adds issue_cnt / stall_cnt outputs.
module fp_mul_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   arb_en,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    output logic                   mul_values_rdy,
    output logic [31:0]            mul_fp_value_1,
    output logic [31:0]            mul_fp_value_2,
    input  logic                   mul_result_rdy,
    input  logic [31:0]            mul_result,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_data,
    output logic                   idle,
    output logic                   tag_err
`ifdef FP_MUL_ARB_STATS_EN
    ,
    output logic [31:0]            issue_cnt,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(TAG_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TAG_DEPTH - 1);
    localparam logic [TAG_W-1:0] IDX_LAST = TAG_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               mul_values_rdy_q, mul_values_rdy_d;
    logic [31:0]        mul_fp_value_1_q, mul_fp_value_1_d;
    logic [31:0]        mul_fp_value_2_q, mul_fp_value_2_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               tag_err_q, tag_err_d;

    logic [TAG_W-1:0]   tag_mem_q [TAG_DEPTH];

    logic [31:0]        a_arr [NUM_REQ];
    logic [31:0]        b_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [TAG_W-1:0]   gnt_idx;
    logic               can_issue;
    logic               push;
    logic               pop;

    // Unpack the flat operand buses into one word per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[32*gi +: 32];
            assign b_arr[gi] = req_b[32*gi +: 32];
        end
    endgenerate

    // Round-robin pick: scan from rr_ptr_q upward, first valid requester wins.
    always_comb begin
        int               idx;
        logic [TAG_W-1:0] idx_t;
        logic             found;
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        idx_t   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_t = TAG_W'(idx);
            if (!found && req_valid[idx_t]) begin
                grant[idx_t] = 1'b1;
                gnt_idx      = idx_t;
                found        = 1'b1;
            end
        end
    end

    // Grants only in RUN with FIFO room; a same-cycle pop does not free a slot.
    assign can_issue = (state_q == ST_RUN) && (count_q < DEPTH_C);
    assign req_ready = can_issue ? grant : '0;
    assign push      = |req_ready;
    assign pop       = mul_result_rdy && (count_q != '0);

    // Next-state, FIFO bookkeeping, issue and response staging.
    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        count_d          = count_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        mul_values_rdy_d = 1'b0;
        mul_fp_value_1_d = mul_fp_value_1_q;
        mul_fp_value_2_d = mul_fp_value_2_q;
        rsp_valid_d      = '0;
        rsp_data_d       = rsp_data_q;
        tag_err_d        = tag_err_q;

        case (state_q)
            ST_IDLE:  if (arb_en) state_d = ST_RUN;
            ST_RUN:   if (!arb_en) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (arb_en) begin
                    state_d = ST_RUN;
                end else if (count_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase

        if (push) begin
            mul_values_rdy_d = 1'b1;
            mul_fp_value_1_d = a_arr[gnt_idx];
            mul_fp_value_2_d = b_arr[gnt_idx];
            rr_ptr_d         = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
            wr_ptr_d         = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rsp_valid_d[tag_mem_q[rd_ptr_q]] = 1'b1;
            rsp_data_d = mul_result;
            rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end else if (mul_result_rdy) begin
            // Result with nothing outstanding: flag it and drop it.
            tag_err_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q          <= ST_IDLE;
            rr_ptr_q         <= '0;
            count_q          <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            mul_values_rdy_q <= 1'b0;
            mul_fp_value_1_q <= '0;
            mul_fp_value_2_q <= '0;
            rsp_valid_q      <= '0;
            rsp_data_q       <= '0;
            tag_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            count_q          <= count_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            mul_values_rdy_q <= mul_values_rdy_d;
            mul_fp_value_1_q <= mul_fp_value_1_d;
            mul_fp_value_2_q <= mul_fp_value_2_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_data_q       <= rsp_data_d;
            tag_err_q        <= tag_err_d;
        end
    end

    // Tag storage; contents need no reset because the pointers gate access.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= gnt_idx;
        end
    end

    assign mul_values_rdy = mul_values_rdy_q;
    assign mul_fp_value_1 = mul_fp_value_1_q;
    assign mul_fp_value_2 = mul_fp_value_2_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign tag_err        = tag_err_q;
    assign idle           = (state_q == ST_IDLE) && (count_q == '0);

`ifdef FP_MUL_ARB_STATS_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Wrapping event counters: transfers, and cycles with demand but no transfer.
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (push) begin
            issue_cnt_d = issue_cnt_q + 32'd1;
        end else if (|req_valid) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Testbench for fp_mul_arbiter: a latency-configurable multiplier model and
// a scoreboard of expected issues and responses, driven by scenario tasks.
module tb_fp_mul_arbiter;

    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic            arb_en;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [32*NR-1:0] req_a;
    logic [32*NR-1:0] req_b;
    logic            mul_values_rdy;
    logic [31:0]     mul_fp_value_1;
    logic [31:0]     mul_fp_value_2;
    logic            mul_result_rdy;
    logic [31:0]     mul_result;
    logic [NR-1:0]   rsp_valid;
    logic [31:0]     rsp_data;
    logic            idle;
    logic            tag_err;
`ifdef FP_MUL_ARB_STATS_EN
    logic [31:0]     issue_cnt;
    logic [31:0]     stall_cnt;
`endif

    fp_mul_arbiter #(.NUM_REQ(NR), .TAG_DEPTH(8)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .arb_en         (arb_en),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .mul_values_rdy (mul_values_rdy),
        .mul_fp_value_1 (mul_fp_value_1),
        .mul_fp_value_2 (mul_fp_value_2),
        .mul_result_rdy (mul_result_rdy),
        .mul_result     (mul_result),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .idle           (idle),
        .tag_err        (tag_err)
`ifdef FP_MUL_ARB_STATS_EN
        ,
        .issue_cnt      (issue_cnt),
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int idx; logic [31:0] a; logic [31:0] b; logic [31:0] p; } op_t;
    typedef struct { int due; logic [31:0] r; } mdl_t;

    op_t  issue_q[$];
    op_t  rsp_q[$];
    mdl_t mdl_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 3;
    int n_grants = 0;

    logic [NR-1:0] s_req_ready, s_rsp_valid;
    logic          s_mvr, s_idle, s_tag_err, s_mrr;
    logic [31:0]   s_fp1, s_fp2, s_rsp_data;

    // Simplified fp32 multiply (normal operands, truncation) for the model.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        r[30:23] = 8'($urandom_range(100, 150));
        return r;
    endfunction

    // One clock: sample at negedge, score issues/responses, record grants,
    // then drive the multiplier model just after the rising edge.
    task automatic step();
        op_t  o;
        mdl_t m;
        logic [NR-1:0] exp_oh;
        @(negedge clk);
        s_req_ready = req_ready;  s_rsp_valid = rsp_valid; s_mvr = mul_values_rdy;
        s_fp1 = mul_fp_value_1;   s_fp2 = mul_fp_value_2;  s_rsp_data = rsp_data;
        s_idle = idle;            s_tag_err = tag_err;     s_mrr = mul_result_rdy;
        if (s_mvr) begin
            n_checks++;
            if (issue_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected: got a=%h b=%h, required no issue", s_fp1, s_fp2);
            end else begin
                o = issue_q.pop_front();
                if (s_fp1 !== o.a || s_fp2 !== o.b) begin
                    n_fail++;
                    $display("FAIL issue_operands: got %h*%h, required %h*%h", s_fp1, s_fp2, o.a, o.b);
                end
            end
            m.due = cyc + lat;
            m.r   = fmul(s_fp1, s_fp2);
            mdl_q.push_back(m);
        end
        if (s_rsp_valid !== '0) begin
            n_checks++;
            if (rsp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got valid=%b data=%h, required none", s_rsp_valid, s_rsp_data);
            end else begin
                o = rsp_q.pop_front();
                exp_oh = NR'(1) << o.idx;
                if (s_rsp_valid !== exp_oh || s_rsp_data !== o.p) begin
                    n_fail++;
                    $display("FAIL rsp_route: got valid=%b data=%h, required valid=%b data=%h",
                             s_rsp_valid, s_rsp_data, exp_oh, o.p);
                end
            end
        end
        if (rstn && s_req_ready !== '0) begin
            n_checks++;
            if ($countones(s_req_ready) != 1 || (s_req_ready & ~req_valid) != '0) begin
                n_fail++;
                $display("FAIL grant_onehot: got ready=%b with valid=%b, required one-hot subset",
                         s_req_ready, req_valid);
            end
            for (int i = 0; i < NR; i++) begin
                if (s_req_ready[i]) begin
                    o.idx = i;
                    o.a   = req_a[32*i +: 32];
                    o.b   = req_b[32*i +: 32];
                    o.p   = fmul(o.a, o.b);
                    issue_q.push_back(o);
                    rsp_q.push_back(o);
                    n_grants++;
                    break;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mdl_q.size() > 0 && mdl_q[0].due <= cyc) begin
            m = mdl_q.pop_front();
            mul_result_rdy = 1'b1;
            mul_result     = m.r;
        end else begin
            mul_result_rdy = 1'b0;
            mul_result     = $urandom;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; arb_en = 1'b0; req_valid = '0;
        step();
        issue_q.delete(); rsp_q.delete(); mdl_q.delete();
        mul_result_rdy = 1'b0;
        step();
        issue_q.delete(); rsp_q.delete(); mdl_q.delete();
        mul_result_rdy = 1'b0;
        n_grants = 0;
        rstn = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && (rsp_q.size() > 0 || issue_q.size() > 0); i++) step();
        n_checks++;
        if (rsp_q.size() != 0 || issue_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d responses pending, required 0", rsp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (s_idle !== 1'b1)    begin n_fail++; $display("FAIL rst_idle: got %b, required 1", s_idle); end
        n_checks++; if (s_mvr !== 1'b0)     begin n_fail++; $display("FAIL rst_mvr: got %b, required 0", s_mvr); end
        n_checks++; if (s_rsp_valid !== '0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b, required 0", s_rsp_valid); end
        n_checks++; if (s_rsp_data !== '0)  begin n_fail++; $display("FAIL rst_rsp_data: got %h, required 0", s_rsp_data); end
        n_checks++; if (s_fp1 !== '0 || s_fp2 !== '0) begin n_fail++; $display("FAIL rst_operands: got %h %h, required 0 0", s_fp1, s_fp2); end
        n_checks++; if (s_tag_err !== 1'b0) begin n_fail++; $display("FAIL rst_tag_err: got %b, required 0", s_tag_err); end
        req_valid = '1;
        step();
        n_checks++; if (s_req_ready !== '0) begin n_fail++; $display("FAIL idle_no_grant: got %b, required 0", s_req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        bit got;
        lat = 3;
        arb_en = 1'b1;
        step();
        req_valid = 4'b0001;
        req_a[31:0] = 32'h3F80_0000;
        req_b[31:0] = 32'h4000_0000;
        step();
        n_checks++; if (s_req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b, required 0001", s_req_ready); end
        req_valid = '0;
        step();
        n_checks++;
        if (s_mvr !== 1'b1 || s_fp1 !== 32'h3F80_0000 || s_fp2 !== 32'h4000_0000) begin
            n_fail++;
            $display("FAIL single_issue: got rdy=%b %h %h, required 1 3f800000 40000000", s_mvr, s_fp1, s_fp2);
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (s_rsp_valid !== '0) begin
                got = 1'b1;
                n_checks++;
                if (s_rsp_valid !== 4'b0001 || s_rsp_data !== 32'h4000_0000) begin
                    n_fail++;
                    $display("FAIL single_rsp: got %b %h, required 0001 40000000", s_rsp_valid, s_rsp_data);
                end
            end
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL single_rsp_timeout: got no response, required one"); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_oh;
        do_reset();
        lat = 3;
        arb_en = 1'b1;
        step();
        for (int i = 0; i < NR; i++) begin
            req_a[32*i +: 32] = rand_fp();
            req_b[32*i +: 32] = rand_fp();
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            step();
            exp_oh = NR'(1) << (k % NR);
            n_checks++;
            if (s_req_ready !== exp_oh) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got %b, required %b", k, s_req_ready, exp_oh);
            end
            req_a[32*(k % NR) +: 32] = rand_fp();
        end
        req_valid = '0;
        wait_drain();
`ifdef FP_MUL_ARB_STATS_EN
        n_checks++; if (issue_cnt !== 32'd5) begin n_fail++; $display("FAIL issue_cnt: got %0d, required 5", issue_cnt); end
`endif
    endtask

    task automatic test_full_stall();
        bit seen_pop;
        int grants_before;
        do_reset();
        lat = 20;
        arb_en = 1'b1;
        step();
        req_valid = '1;
        seen_pop = 1'b0;
        grants_before = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!seen_pop && s_mrr) begin
                seen_pop = 1'b1;
                grants_before = n_grants;
                n_checks++;
                if (s_req_ready !== '0) begin n_fail++; $display("FAIL stall_pop_same_cycle: got %b, required 0", s_req_ready); end
                step();
                n_checks++;
                if (s_req_ready === '0) begin n_fail++; $display("FAIL stall_release: got %b, required a grant", s_req_ready); end
                break;
            end
            if (n_grants >= 8 && i >= 8) begin
                n_checks++;
                if (s_req_ready !== '0) begin n_fail++; $display("FAIL stall_full[%0d]: got %b, required 0", i, s_req_ready); end
            end
        end
        n_checks++;
        if (!seen_pop || grants_before != 8) begin
            n_fail++;
            $display("FAIL stall_count: got %0d grants before first result, required 8", grants_before);
        end
        req_valid = '0;
        wait_drain();
    endtask

    task automatic test_drain();
        int nr;
        bit done;
        do_reset();
        lat = 10;
        arb_en = 1'b1;
        step();
        req_a[63:32] = 32'h4040_0000;  req_b[63:32] = 32'h4080_0000;
        req_valid = 4'b0010;  step();
        n_checks++; if (s_req_ready !== 4'b0010) begin n_fail++; $display("FAIL drain_g1: got %b, required 0010", s_req_ready); end
        req_a[95:64] = rand_fp(); req_b[95:64] = rand_fp();
        req_valid = 4'b0100;  step();
        req_a[127:96] = rand_fp(); req_b[127:96] = rand_fp();
        req_valid = 4'b1000;  step();
        req_valid = '0; arb_en = 1'b0;
        step();
        req_valid = '1;
        nr = 0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            n_checks++;
            if (s_req_ready !== '0) begin n_fail++; $display("FAIL drain_no_grant: got %b, required 0", s_req_ready); end
            if (s_rsp_valid !== '0) begin
                nr++;
                if (nr == 1) begin
                    n_checks++;
                    if (s_rsp_valid !== 4'b0010 || s_rsp_data !== 32'h4140_0000) begin
                        n_fail++;
                        $display("FAIL drain_rsp1: got %b %h, required 0010 41400000", s_rsp_valid, s_rsp_data);
                    end
                end
                if (nr == 3) begin
                    n_checks++; if (s_idle !== 1'b0) begin n_fail++; $display("FAIL drain_idle_early: got %b, required 0", s_idle); end
                    step();
                    n_checks++; if (s_idle !== 1'b1) begin n_fail++; $display("FAIL drain_idle_rise: got %b, required 1", s_idle); end
                    done = 1'b1;
                end
            end
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL drain_timeout: got %0d responses, required 3", nr); end
        req_valid = '0;
    endtask

    task automatic test_error_reset();
        mul_result_rdy = 1'b1; mul_result = 32'hDEAD_BEEF;
        step();
        step();
        n_checks++; if (s_rsp_valid !== '0) begin n_fail++; $display("FAIL err_no_rsp: got %b, required 0", s_rsp_valid); end
        n_checks++; if (s_tag_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b, required 1", s_tag_err); end
        step();
        n_checks++; if (s_tag_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b, required 1", s_tag_err); end
        lat = 6;
        arb_en = 1'b1;
        step();
        req_valid = '1;
        for (int i = 0; i < 5; i++) step();
        do_reset();
        n_checks++;
        if ({s_idle, s_tag_err, s_req_ready, s_mvr, s_rsp_valid, s_rsp_data, s_fp1, s_fp2} !==
            {1'b1, 1'b0, 4'b0, 1'b0, 4'b0, 96'b0}) begin
            n_fail++;
            $display("FAIL midreset_outputs: got idle=%b err=%b rdy=%b mvr=%b rv=%b rd=%h fp=%h/%h, required reset values",
                     s_idle, s_tag_err, s_req_ready, s_mvr, s_rsp_valid, s_rsp_data, s_fp1, s_fp2);
        end
        mul_result_rdy = 1'b1; mul_result = 32'h1234_5678;
        step();
        step();
        n_checks++;
        if (s_tag_err !== 1'b1 || s_rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL midreset_count_zero: got err=%b rv=%b, required err=1 rv=0", s_tag_err, s_rsp_valid);
        end
    endtask

    initial begin
        rstn = 1'b0; arb_en = 1'b0; req_valid = '0;
        req_a = '0; req_b = '0;
        mul_result_rdy = 1'b0; mul_result = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_drain();
        test_error_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
